// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/stall controller for the 5-stage CPU: freeze, redirect flush,
// load-use bubble and fetch-wait handling, plus saturating stall counters.
module hazard_ctrl_unit #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_IFID_rs1_addr,
  input  logic [4:0]       i_IFID_rs2_addr,
  input  logic             i_IFID_uses_rs2,
  input  logic [4:0]       i_IDEX_rd_addr,
  input  logic             i_IDEX_memRead,
  input  logic             i_EX_branch_taken,
  input  logic             i_EXMEM_memAccess,
  input  logic             i_d_valid_data,
  input  logic             i_i_valid_inst,
  input  logic             i_cnt_clr,
  output logic             o_PC_write,
  output logic             o_IFID_write,
  output logic             o_IDEX_write,
  output logic             o_EXMEM_write,
  output logic             o_IFID_flush,
  output logic             o_IDEX_flush,
  output logic             o_MEMWB_flush,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cnt_loaduse,
  output logic [CNT_W-1:0] o_cnt_dstall,
  output logic [CNT_W-1:0] o_cnt_flush
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_IDROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_F, w_B, w_L, w_W;
  logic             w_act_B, w_act_L;
  logic [CNT_W-1:0] r_cnt_loaduse, r_cnt_dstall, r_cnt_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_F = i_EXMEM_memAccess & ~i_d_valid_data;
  assign w_B = i_EX_branch_taken;
  assign w_L = i_IDEX_memRead & (i_IDEX_rd_addr != 5'd0) &
               ((i_IDEX_rd_addr == i_IFID_rs1_addr) |
                (i_IFID_uses_rs2 & (i_IDEX_rd_addr == i_IFID_rs2_addr)));
  assign w_W = ~i_i_valid_inst;

  // Freeze masks everything below it; these are the actions actually taken.
  assign w_act_B = ~w_F & w_B;
  assign w_act_L = ~w_F & ~w_B & w_L;

  always_comb begin
    o_PC_write    = 1'b1;
    o_IFID_write  = 1'b1;
    o_IDEX_write  = 1'b1;
    o_EXMEM_write = 1'b1;
    o_IFID_flush  = 1'b0;
    o_IDEX_flush  = 1'b0;
    o_MEMWB_flush = 1'b0;
    w_state_nxt   = r_state;

    if (w_F) begin
      o_PC_write    = 1'b0;
      o_IFID_write  = 1'b0;
      o_IDEX_write  = 1'b0;
      o_EXMEM_write = 1'b0;
      o_MEMWB_flush = 1'b1;
    end else if (w_B) begin
      o_IFID_flush  = 1'b1;
      o_IDEX_flush  = 1'b1;
    end else if (w_L) begin
      o_PC_write    = 1'b0;
      o_IFID_write  = 1'b0;
      o_IDEX_flush  = 1'b1;
    end else if (w_W) begin
      o_PC_write    = 1'b0;
      o_IFID_flush  = 1'b1;
    end

    // Wrong-path word returning: discard it and refetch from the held target.
    if (r_state == ST_IDROP && i_i_valid_inst) begin
      o_PC_write   = 1'b0;
      o_IFID_flush = 1'b1;
    end

    case (r_state)
      ST_RUN: begin
        if (w_act_B && w_W)  w_state_nxt = ST_IDROP;
        else if (!w_F && w_W) w_state_nxt = ST_IWAIT;
      end
      ST_IWAIT: begin
        if (i_i_valid_inst && !w_F) w_state_nxt = ST_RUN;
        else if (w_act_B && w_W)    w_state_nxt = ST_IDROP;
      end
      ST_IDROP: begin
        if (i_i_valid_inst) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase

    if (!i_rst_n) begin
      o_PC_write    = 1'b0;
      o_IFID_write  = 1'b0;
      o_IDEX_write  = 1'b0;
      o_EXMEM_write = 1'b0;
      o_IFID_flush  = 1'b1;
      o_IDEX_flush  = 1'b1;
      o_MEMWB_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_cnt_loaduse <= '0;
      r_cnt_dstall  <= '0;
      r_cnt_flush   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_cnt_clr) begin
        r_cnt_loaduse <= '0;
        r_cnt_dstall  <= '0;
        r_cnt_flush   <= '0;
      end else begin
        r_cnt_loaduse <= sat_inc(r_cnt_loaduse, w_act_L);
        r_cnt_dstall  <= sat_inc(r_cnt_dstall, w_F);
        r_cnt_flush   <= sat_inc(r_cnt_flush, w_act_B);
      end
    end
  end

  assign o_state       = r_state;
  assign o_cnt_loaduse = r_cnt_loaduse;
  assign o_cnt_dstall  = r_cnt_dstall;
  assign o_cnt_flush   = r_cnt_flush;

endmodule
